// File: rtl/edge_event_arbiter_if.sv
// Event output handshake between edge_event_arbiter (master) and its consumer (slave).
interface edge_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_rise;

    modport master (output evt_valid, output evt_id, output evt_rise, input evt_ready);
    modport slave  (input evt_valid, input evt_id, input evt_rise, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detection with one pending event per channel, sticky overflow
// and a round-robin arbiter sharing a single valid/ready event port.
module edge_event_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         data,
    input  logic [1:0]           mode,
    input  logic [N-1:0]         enable_mask,
    output logic [N-1:0]         overflow,
    input  logic [N-1:0]         ovf_clr,
    edge_event_arbiter_if.master evt
);

    typedef enum logic {S_IDLE = 1'b0, S_PRESENT = 1'b1} state_t;

    localparam logic [ID_W:0] L_N = (ID_W+1)'(N);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_prev;
    logic            r_primed;
    logic [N-1:0]    r_pend;
    logic [N-1:0]    r_ptype;
    logic [N-1:0]    r_ovf;
    logic [ID_W-1:0] r_last_grant;
    logic            r_evt_valid;
    logic [ID_W-1:0] r_evt_id;
    logic            r_evt_rise;

    logic            w_rise_en;
    logic            w_fall_en;
    logic [N-1:0]    w_qrise;
    logic [N-1:0]    w_qfall;
    logic [N-1:0]    w_edge;
    logic [N-1:0]    w_acc_vec;
    logic            w_found;
    logic [ID_W-1:0] w_sel;
    logic [ID_W:0]   w_idx;
    logic            w_load;
    logic            w_accept;

    // Edges are suppressed for the first cycle out of reset so prev can prime
    assign w_rise_en = (mode == 2'b00) || (mode == 2'b10);
    assign w_fall_en = (mode == 2'b01) || (mode == 2'b10);
    assign w_qrise   = {N{r_primed & w_rise_en}} & enable_mask & data & ~r_prev;
    assign w_qfall   = {N{r_primed & w_fall_en}} & enable_mask & ~data & r_prev;
    assign w_edge    = w_qrise | w_qfall;

    always_comb begin
        w_acc_vec = '0;
        if (w_accept) begin
            w_acc_vec[r_evt_id] = 1'b1;
        end
    end

    // Round-robin search starting one past the last granted channel
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = {1'b0, r_last_grant} + k[ID_W:0];
            if (w_idx >= L_N) begin
                w_idx = w_idx - L_N;
            end
            if (!w_found && r_pend[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (evt.evt_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_valid  <= 1'b0;
            r_evt_id     <= '0;
            r_evt_rise   <= 1'b0;
            r_last_grant <= ID_W'(N-1);
        end else if (w_load) begin
            r_evt_valid <= 1'b1;
            r_evt_id    <= w_sel;
            r_evt_rise  <= r_ptype[w_sel];
        end else if (w_accept) begin
            r_evt_valid  <= 1'b0;
            r_last_grant <= r_evt_id;
        end
    end

    // An edge arriving as the channel is accepted replaces the event instead of overflowing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev   <= '0;
            r_primed <= 1'b0;
            r_pend   <= '0;
            r_ptype  <= '0;
            r_ovf    <= '0;
        end else begin
            r_prev   <= data;
            r_primed <= 1'b1;
            for (int i = 0; i < N; i++) begin
                if (w_edge[i] && (!r_pend[i] || w_acc_vec[i])) begin
                    r_pend[i]  <= 1'b1;
                    r_ptype[i] <= w_qrise[i];
                end else if (w_acc_vec[i]) begin
                    r_pend[i] <= 1'b0;
                end
                if (w_edge[i] && r_pend[i] && !w_acc_vec[i]) begin
                    r_ovf[i] <= 1'b1;
                end else if (ovf_clr[i]) begin
                    r_ovf[i] <= 1'b0;
                end
            end
        end
    end

    assign evt.evt_valid = r_evt_valid;
    assign evt.evt_id    = r_evt_id;
    assign evt.evt_rise  = r_evt_rise;
    assign overflow      = r_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: expected {id, rise} pairs are queued as
// stimulus is driven and popped on every accepted handshake.
module tb_edge_event_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] data;
    logic [1:0]   mode;
    logic [N-1:0] enable_mask;
    logic [N-1:0] overflow;
    logic [N-1:0] ovf_clr;

    edge_event_arbiter_if #(.ID_W(ID_W)) evt_if ();

    edge_event_arbiter #(.N(N), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .mode        (mode),
        .enable_mask (enable_mask),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .evt         (evt_if)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [ID_W:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ID_W:0] mk(input int id, input logic rise);
        return {id[ID_W-1:0], rise};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_vld"}, evt_if.evt_valid, 0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_evt", 32'({evt_if.evt_id, evt_if.evt_rise}), 32'hdead);
            end else begin
                check("evt", 32'({evt_if.evt_id, evt_if.evt_rise}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        data             = '1;
        mode             = 2'b00;
        enable_mask      = '1;
        ovf_clr          = '0;
        evt_if.evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vld", evt_if.evt_valid, 0);
        check("rst_id", evt_if.evt_id, 0);
        check("rst_rise", evt_if.evt_rise, 0);
        check("rst_ovf", overflow, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(6);
        wait_drain("prime");

        // Round robin from reset, again from last_grant=3, then 3 before 1 after grant 1
        tick(1); data = '0;
        tick(3); data = '1;
        for (int i = 0; i < N; i++) exp_q.push_back(mk(i, 1'b1));
        wait_drain("rr1");
        tick(1); data = '0;
        tick(3); data = '1;
        for (int i = 0; i < N; i++) exp_q.push_back(mk(i, 1'b1));
        wait_drain("rr2");
        tick(1); data = '0;
        tick(3); data = 4'b0010;
        exp_q.push_back(mk(1, 1'b1));
        wait_drain("rr3a");
        tick(1); data = '0;
        tick(3); data = 4'b1010;
        exp_q.push_back(mk(3, 1'b1));
        exp_q.push_back(mk(1, 1'b1));
        wait_drain("rr3b");

        // Single rising edge with latency
        tick(1); data = '0;
        tick(3); data[2] = 1'b1;
        exp_q.push_back(mk(2, 1'b1));
        @(negedge clk);
        @(negedge clk);
        check("lat_e0_vld", evt_if.evt_valid, 0);
        @(negedge clk);
        check("lat_e1_vld", evt_if.evt_valid, 1);
        check("lat_e1_id", evt_if.evt_id, 2);
        check("lat_e1_rise", evt_if.evt_rise, 1);
        @(negedge clk);
        check("one_cycle_vld", evt_if.evt_valid, 0);
        wait_drain("single");

        // Both-edge mode
        tick(1); mode = 2'b10;
        tick(1); data[0] = 1'b1;
        exp_q.push_back(mk(0, 1'b1));
        tick(6); data[0] = 1'b0;
        exp_q.push_back(mk(0, 1'b0));
        wait_drain("both");
        check("both_ovf", overflow, 0);
        tick(1); mode = 2'b00;

        // Backpressure and overflow
        tick(1); data = '0;
        tick(3); evt_if.evt_ready = 1'b0; data[1] = 1'b1;
        exp_q.push_back(mk(1, 1'b1));
        tick(4); data[1] = 1'b0;
        tick(2); data[1] = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_vld", evt_if.evt_valid, 1);
            check("bp_id", evt_if.evt_id, 1);
            check("bp_rise", evt_if.evt_rise, 1);
        end
        check("bp_ovf_set", overflow, 4'b0010);
        tick(1); evt_if.evt_ready = 1'b1;
        wait_drain("bp");
        check("bp_ovf_sticky", overflow, 4'b0010);
        tick(1); ovf_clr = 4'b0010;
        tick(1); ovf_clr = '0;
        @(negedge clk);
        check("bp_ovf_clr", overflow, 0);

        // Mask and disabled detection
        tick(1); data = '0;
        tick(3); enable_mask = 4'b0111; data[3] = 1'b1;
        tick(6);
        check("mask_vld", evt_if.evt_valid, 0);
        wait_drain("mask");
        check("mask_ovf", overflow, 0);
        tick(1); enable_mask = '1; mode = 2'b11; data = '0;
        tick(2); data = '1;
        tick(2); data = '0;
        tick(2); data = '1;
        wait_drain("disable");
        check("disable_ovf", overflow, 0);
        tick(1); mode = 2'b00;

        // Reset while an event is presented
        tick(1); data = '0;
        tick(3); evt_if.evt_ready = 1'b0; data[0] = 1'b1;
        for (int i = 0; i < 10 && evt_if.evt_valid !== 1'b1; i++) @(negedge clk);
        check("mid_vld_up", evt_if.evt_valid, 1);
        tick(1); data[0] = 1'b0;
        tick(2); data[0] = 1'b1;
        tick(2);
        check("mid_ovf_set", overflow, 4'b0001);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_vld", evt_if.evt_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        tick(1); rst = 1'b0; evt_if.evt_ready = 1'b1;
        tick(8);
        wait_drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event controller that sits on top of the positive-edge detector datapath. It samples N synchronous input lines, detects configurable edges per line and holds one pending event per channel. It then shares a single event output port between the channels using round-robin arbitration with a valid/ready handshake. Each channel has a sticky overflow flag for events lost while one was already pending.

## Interface
Parameters:
- N, 4, number of input channels (2..16)
- ID_W, 2, width of event channel id; must equal clog2(N)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- data  input  N  per-channel input lines, already synchronous to clk
- mode  input  2  edge select, global: 00 rising, 01 falling, 10 both, 11 detection disabled
- enable_mask  input  N  1 = channel may set pending; 0 = new edges on that channel ignored
- evt_valid  output  1  event presented on evt_id/evt_rise
- evt_ready  input  1  consumer accepts the event when high with evt_valid
- evt_id  output  ID_W  channel number of presented event
- evt_rise  output  1  1 = rising edge, 0 = falling edge
- overflow  output  N  sticky per-channel lost-event flag
- ovf_clr  input  N  per-channel overflow clear, 1-cycle pulse

## Operation
- Edge detect:
  - prev[N-1:0] registers data every cycle.
  - rise = data & ~prev; fall = ~data & prev.
  - Qualified by mode and enable_mask.
- Priming:
  - In the first cycle after rst deasserts, prev loads data and no edges are detected.
  - A line held high through reset produces no event.
- Pending:
  - pend[i] is set on a qualified edge; ptype[i] records rise (1) or fall (0).
  - pend[i] is cleared only on handshake acceptance of channel i.
- Overflow:
  - A qualified edge on channel i while pend[i]=1 sets overflow[i].
  - The original ptype[i] is kept; the oldest event wins.
  - Exception: an edge in the same cycle channel i is accepted re-sets pend[i] with the new type. No overflow is raised in this case.
  - If ovf_clr[i] and an overflow set coincide, the set wins.
- Arbiter FSM, two states:
  - IDLE:
    - If any pend is set, select the first set channel searching from last_grant+1 upward, modulo N.
    - Register the selection into evt_id/evt_rise, assert evt_valid and go to PRESENT.
    - Otherwise stay in IDLE.
  - PRESENT:
    - Hold evt_valid, evt_id and evt_rise stable until evt_valid & evt_ready.
    - On acceptance: clear pend[evt_id], set last_grant=evt_id, deassert evt_valid, go to IDLE.
- Mode and mask changes:
  - Take effect on the next detected edge.
  - Do not clear existing pending events.
  - A presented event is never withdrawn.
- Reset values: evt_valid=0, evt_id=0, evt_rise=0, overflow=0, pend=0, ptype=0, prev=0, state=IDLE, last_grant=N-1 (channel 0 has first priority), primed=0.
- Reset mid-handshake: all events are discarded and evt_valid drops in the cycle after rst is sampled high.

## Timing
- Latency from input line to event:
  - The line changes before clock edge E0 and is sampled with prev differing; pend is set after E0.
  - The FSM selects at E1, so evt_valid=1 after E1. Latency is 2 cycles.
- Throughput: at most one event per 2 cycles (accept cycle, then IDLE select cycle).
- evt_ready may be held high permanently.
- Events for a single channel are delivered in order.
- Inter-channel order follows the round-robin scheme, not arrival time.
- Outputs are registered with no combinational path from evt_ready, data or mode to any output.
- Starvation bound: a pending channel is presented within N grants.

## Test plan
- Single rising edge, mode=00:
  - Stimulus: data[2] 0->1, evt_ready=1.
  - Required: evt_valid high 2 cycles later with evt_id=2, evt_rise=1, for one cycle; no further events.
- Both-edge mode=10:
  - Stimulus: data[0] pulses high for 6 cycles.
  - Required: two events on channel 0, evt_rise=1 then evt_rise=0; overflow=0.
- Round-robin:
  - Stimulus: channels 0..3 all rise in the same cycle; evt_ready=1.
  - Required: ids delivered 0,1,2,3.
  - Follow-up: a second simultaneous burst with last_grant=3 again delivers 0,1,2,3.
  - Follow-up: with only channels 1 and 3 pending after grant 1, the order is 3 then 1.
- Backpressure and overflow:
  - Stimulus: evt_ready=0; channel 1 rises, falls and rises again (mode=00).
  - Required: evt_id=1 held stable and overflow[1]=1.
  - After acceptance: exactly one event delivered; ovf_clr[1] pulse returns overflow[1] to 0.
- Mask and disable:
  - Stimulus: enable_mask[3]=0, edge on channel 3; then mode=11 with edges on all channels.
  - Required: no events and no overflow in either case.
- Reset behaviour:
  - Stimulus: data=4'b1111 held through rst.
  - Required: no events after reset.
  - Stimulus: rst asserted while evt_valid=1.
  - Required: evt_valid=0 and overflow=0 one cycle later; the old pending event is never delivered.
